// File: rtl/lib_axi_pkg.sv
// Shared AXI4-Lite definitions for the local<->AXI bridge family.
package lib_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
  } state_t;

endpackage

// File: rtl/lib_watchdog_cnt.sv
// Clearable, enable-gated cycle counter; tc marks the cycle whose increment reaches TIMEOUT_CYC.
module lib_watchdog_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign tc = (TIMEOUT_CYC != 0) && en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/lib_local2axi.sv
// AXI4-Lite master bridge: one local read/write command at a time, issued as a single AXI beat,
// with a watchdog that forces a SLVERR response if the slave hangs.
module lib_local2axi
  import lib_axi_pkg::*;
#(
  parameter int AXI_AW      = 12,
  parameter int AXI_DW      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [AXI_DW-1:0]     cmd_wdata,

  output logic                  rsp_valid,
  output logic [AXI_DW-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic [AXI_AW-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [AXI_DW-1:0]     M_AXI_WDATA,
  output logic [AXI_DW/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [AXI_AW-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [AXI_DW-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  state_t state_reg, state_next;

  logic              awvalid_reg, awvalid_next;
  logic              wvalid_reg, wvalid_next;
  logic              bready_reg, bready_next;
  logic              arvalid_reg, arvalid_next;
  logic              rready_reg, rready_next;
  logic [AXI_AW-1:0] awaddr_reg, awaddr_next;
  logic [AXI_DW-1:0] wdata_reg, wdata_next;
  logic [AXI_AW-1:0] araddr_reg, araddr_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [AXI_DW-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]        rsp_resp_reg, rsp_resp_next;
  logic              rsp_timeout_reg, rsp_timeout_next;

  logic wd_clr, wd_en, wd_tc;
  logic aw_pend_next, w_pend_next;

  // AW and W retire independently; each stays pending until its own handshake.
  assign aw_pend_next = awvalid_reg && !M_AXI_AWREADY;
  assign w_pend_next  = wvalid_reg  && !M_AXI_WREADY;

  assign wd_clr = (state_reg == ST_IDLE);
  assign wd_en  = (state_reg != ST_IDLE) && (state_reg != ST_RSP);

  lib_watchdog_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk  (M_AXI_ACLK),
    .srst (M_AXI_ARESET),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_reg       <= ST_IDLE;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      awaddr_reg      <= '0;
      wdata_reg       <= '0;
      araddr_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= RESP_OKAY;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      awaddr_reg      <= awaddr_next;
      wdata_reg       <= wdata_next;
      araddr_reg      <= araddr_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_resp_reg    <= rsp_resp_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // A completed B/R handshake wins over a coincident timeout so real data is never dropped.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (cmd_valid) state_next = cmd_wr ? ST_WR_AW_W : ST_RD_AR;
      ST_WR_AW_W: begin
        if (wd_tc) begin
          state_next = ST_RSP;
        end else if (!aw_pend_next && !w_pend_next) begin
          state_next = ST_WR_B;
        end
      end
      ST_WR_B:    if (M_AXI_BVALID || wd_tc) state_next = ST_RSP;
      ST_RD_AR: begin
        if (wd_tc) begin
          state_next = ST_RSP;
        end else if (M_AXI_ARREADY) begin
          state_next = ST_RD_R;
        end
      end
      ST_RD_R:    if (M_AXI_RVALID || wd_tc) state_next = ST_RSP;
      ST_RSP:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    bready_next      = bready_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    awaddr_next      = awaddr_reg;
    wdata_next       = wdata_reg;
    araddr_next      = araddr_reg;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_resp_next    = rsp_resp_reg;
    rsp_timeout_next = rsp_timeout_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_wr) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_wdata;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
          end
        end
      end
      ST_WR_AW_W: begin
        if (wd_tc) begin
          awvalid_next = 1'b0;
          wvalid_next  = 1'b0;
        end else begin
          awvalid_next = aw_pend_next;
          wvalid_next  = w_pend_next;
          bready_next  = !aw_pend_next && !w_pend_next;
        end
      end
      ST_WR_B: begin
        if (M_AXI_BVALID || wd_tc) begin
          bready_next = 1'b0;
        end
      end
      ST_RD_AR: begin
        if (wd_tc) begin
          arvalid_next = 1'b0;
        end else if (M_AXI_ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (M_AXI_RVALID || wd_tc) begin
          rready_next = 1'b0;
        end
      end
      default: ;
    endcase

    if ((state_reg == ST_WR_B) && M_AXI_BVALID) begin
      rsp_valid_next   = 1'b1;
      rsp_rdata_next   = '0;
      rsp_resp_next    = M_AXI_BRESP;
      rsp_timeout_next = 1'b0;
    end else if ((state_reg == ST_RD_R) && M_AXI_RVALID) begin
      rsp_valid_next   = 1'b1;
      rsp_rdata_next   = M_AXI_RDATA;
      rsp_resp_next    = M_AXI_RRESP;
      rsp_timeout_next = 1'b0;
    end else if (wd_tc) begin
      rsp_valid_next   = 1'b1;
      rsp_rdata_next   = '0;
      rsp_resp_next    = RESP_SLVERR;
      rsp_timeout_next = 1'b1;
    end
  end

  assign cmd_ready     = (state_reg == ST_IDLE);
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign rsp_timeout   = rsp_timeout_reg;

  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_lib_local2axi.sv
// Scoreboard bench for lib_local2axi: directed commands against a delay-programmable AXI4-Lite slave model.
module tb_lib_local2axi;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          M_AXI_ARESET;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic          M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  lib_local2axi #(.AXI_AW(AW), .AXI_DW(DW), .TIMEOUT_CYC(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int aw_n, w_n, ar_n, aw_first, w_first, bready_first, ar_first, rready_first;
    int lat, rsp_n, rdy_after, busy_bad;
  } obs_t;

  // Slave model knobs and observations
  int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    bresp_val = 2'b00;
  logic [DW-1:0] rdata_val = '0;
  int            aw_tot, w_tot, b_tot, ar_tot, r_tot;
  int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [AW-1:0] awaddr_seen, araddr_seen;
  logic [DW-1:0] wdata_seen;
  logic [DW/8-1:0] wstrb_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Slave: handshakes counted on the rising edge, responses driven on the falling edge.
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_tot = 0; w_tot = 0; b_tot = 0; ar_tot = 0; r_tot = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    forever begin
      @(posedge clk);
      if (M_AXI_ARESET) begin
        aw_tot = 0; w_tot = 0; b_tot = 0; ar_tot = 0; r_tot = 0;
      end else begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_tot++; awaddr_seen = M_AXI_AWADDR; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          w_tot++; wdata_seen = M_AXI_WDATA; wstrb_seen = M_AXI_WSTRB;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_tot++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_tot++; araddr_seen = M_AXI_ARADDR; end
        if (M_AXI_RVALID && M_AXI_RREADY) r_tot++;
      end
      @(negedge clk);
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++; end
      else begin M_AXI_AWREADY = 0; aw_wait = 0; end
      if (M_AXI_WVALID) begin M_AXI_WREADY = (w_wait >= w_delay); w_wait++; end
      else begin M_AXI_WREADY = 0; w_wait = 0; end
      if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_wait >= ar_delay); ar_wait++; end
      else begin M_AXI_ARREADY = 0; ar_wait = 0; end
      if (((aw_tot < w_tot) ? aw_tot : w_tot) > b_tot) begin
        M_AXI_BVALID = (b_wait >= b_delay); M_AXI_BRESP = bresp_val; b_wait++;
      end else begin M_AXI_BVALID = 0; b_wait = 0; end
      if (ar_tot > r_tot) begin
        M_AXI_RVALID = (r_wait >= r_delay); M_AXI_RDATA = rdata_val; M_AXI_RRESP = 2'b00; r_wait++;
      end else begin M_AXI_RVALID = 0; r_wait = 0; end
    end
  end

  // Response monitor: every rsp_valid pops one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=rsp_valid required=none resp=%b to=%b", rsp_resp, rsp_timeout);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
        end
      end
    end
  end

  // Presents one command; returns at the falling edge of the first cycle after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input bit expect_rsp, input logic [DW-1:0] e_rdata,
                       input logic [1:0] e_resp, input logic e_to);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    if (expect_rsp) begin
      e.rdata = e_rdata; e.resp = e_resp; e.to = e_to;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic observe(input int ncyc, output obs_t o);
    o = '{default: 0};
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      if (M_AXI_AWVALID) begin o.aw_n++; if (o.aw_first == 0) o.aw_first = c; end
      if (M_AXI_WVALID)  begin o.w_n++;  if (o.w_first == 0)  o.w_first = c;  end
      if (M_AXI_ARVALID) begin o.ar_n++; if (o.ar_first == 0) o.ar_first = c; end
      if (M_AXI_BREADY && o.bready_first == 0) o.bready_first = c;
      if (M_AXI_RREADY && o.rready_first == 0) o.rready_first = c;
      if (rsp_valid) begin o.rsp_n++; if (o.lat == 0) o.lat = c; end
      if ((o.lat == 0 || c <= o.lat) && cmd_ready) o.busy_bad++;
      else if (o.lat != 0 && c > o.lat && o.rdy_after == 0 && cmd_ready) o.rdy_after = c;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    obs_t o;
    int n, b_before;
    M_AXI_ARESET = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_valid_ready", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("reset_addr", {8'd0, M_AXI_AWADDR, M_AXI_ARADDR}, 32'd0);
    chk("reset_wdata", M_AXI_WDATA, 32'd0);
    chk("reset_rsp", {28'd0, rsp_valid, rsp_resp, rsp_timeout}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    M_AXI_ARESET = 0;

    // Zero-wait write
    issue(1, 12'h004, 32'hDEADBEEF, 1, 32'h0, 2'b00, 1'b0);
    observe(12, o);
    $display("txn write 0x004 lat=%0d", o.lat);
    chk("t1_aw_first", o.aw_first, 1);
    chk("t1_w_first", o.w_first, 1);
    chk("t1_bready_first", o.bready_first, 2);
    chk("t1_lat", o.lat, 3);
    chk("t1_rsp_n", o.rsp_n, 1);
    chk("t1_next_ready", o.rdy_after, 4);
    chk("t1_busy", o.busy_bad, 0);
    chk("t1_awaddr", {20'd0, awaddr_seen}, 32'h004);
    chk("t1_wdata", wdata_seen, 32'hDEADBEEF);
    chk("t1_wstrb", {28'd0, wstrb_seen}, 32'hF);

    // AWREADY late by 3 cycles, WREADY immediate
    aw_delay = 3; b_before = b_tot;
    issue(1, 12'h008, 32'h11112222, 1, 32'h0, 2'b00, 1'b0);
    observe(20, o);
    $display("txn write 0x008 aw_delay=3 lat=%0d", o.lat);
    chk("t2_aw_cycles", o.aw_n, 4);
    chk("t2_w_cycles", o.w_n, 1);
    chk("t2_lat", o.lat, 6);
    chk("t2_rsp_n", o.rsp_n, 1);
    chk("t2_b_handshakes", b_tot - b_before, 1);
    aw_delay = 0;

    // Read with RVALID late by 5 cycles
    r_delay = 5; rdata_val = 32'hA5A5_0001;
    issue(0, 12'h010, 32'h0, 1, 32'hA5A5_0001, 2'b00, 1'b0);
    observe(20, o);
    $display("txn read 0x010 r_delay=5 lat=%0d", o.lat);
    chk("t3_lat", o.lat, 8);
    chk("t3_rsp_n", o.rsp_n, 1);
    chk("t3_busy", o.busy_bad, 0);
    chk("t3_araddr", {20'd0, araddr_seen}, 32'h010);
    r_delay = 0;

    // Slave error on write
    bresp_val = 2'b10;
    issue(1, 12'h00C, 32'h0BADF00D, 1, 32'h0, 2'b10, 1'b0);
    observe(10, o);
    $display("txn write 0x00C bresp=10 lat=%0d", o.lat);
    chk("t4_lat", o.lat, 3);
    bresp_val = 2'b00;

    // Zero-wait read
    rdata_val = 32'h1234_5678;
    issue(0, 12'h008, 32'h0, 1, 32'h1234_5678, 2'b00, 1'b0);
    observe(10, o);
    $display("txn read 0x008 lat=%0d", o.lat);
    chk("t5_ar_first", o.ar_first, 1);
    chk("t5_rready_first", o.rready_first, 2);
    chk("t5_lat", o.lat, 3);
    chk("t5_next_ready", o.rdy_after, 4);

    // Hung slave: ARREADY never comes
    ar_delay = 1000;
    issue(0, 12'h014, 32'h0, 1, 32'h0, 2'b10, 1'b1);
    observe(25, o);
    $display("txn read 0x014 hang lat=%0d", o.lat);
    chk("t6_ar_cycles", o.ar_n, 16);
    chk("t6_lat", o.lat, 17);
    chk("t6_rsp_n", o.rsp_n, 1);
    chk("t6_next_ready", o.rdy_after, 18);
    ar_delay = 0; rdata_val = 32'hCAFE_0018;
    issue(0, 12'h018, 32'h0, 1, 32'hCAFE_0018, 2'b00, 1'b0);
    observe(10, o);
    $display("txn read 0x018 after timeout lat=%0d", o.lat);
    chk("t6_recover_lat", o.lat, 3);

    // Reset while waiting for B
    b_delay = 50;
    issue(1, 12'h020, 32'h55AA55AA, 0, 32'h0, 2'b00, 1'b0);
    n = 0;
    while (!M_AXI_BREADY && n < 20) begin @(negedge clk); n++; end
    chk("t7_bready_before_reset", {31'd0, M_AXI_BREADY}, 32'd1);
    M_AXI_ARESET = 1;
    @(negedge clk);
    $display("txn write 0x020 reset in WR_B");
    chk("t7_valid_ready", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("t7_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t7_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    M_AXI_ARESET = 0; b_delay = 0;
    repeat (20) @(negedge clk);
    issue(1, 12'h024, 32'h0000_0024, 1, 32'h0, 2'b00, 1'b0);
    observe(10, o);
    $display("txn write 0x024 after reset lat=%0d", o.lat);
    chk("t7_recover_lat", o.lat, 3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lib_local2axi.md
# lib_local2axi

AXI4-Lite master bridge: takes single-beat read/write commands from a local PL requester and issues them as AXI4-Lite transactions toward a slave (e.g. a `lib_axi2local` register map or a PS HP/GP slave port). It is the initiator-side counterpart of our AXI-to-local slave bridge. It sits between PL control logic (sequencers, self-test engines) and the AXI interconnect. Only one transaction is outstanding at a time, and a bus watchdog guarantees that every accepted command gets a response.

## Interface

Parameters:
- AXI_AW, 12, address width.
- AXI_DW, 32, data width; strobe width is AXI_DW/8.
- TIMEOUT_CYC, 1024, watchdog limit in cycles per transaction; 0 disables the watchdog.

Ports:
- M_AXI_ACLK  in  1  clock; one clock for everything.
- M_AXI_ARESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  local command request.
- cmd_ready  out  1  bridge idle and accepting a command.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_AW  byte address.
- cmd_wdata  in  AXI_DW  write data.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  AXI_DW  read data; 0 for writes.
- rsp_resp  out  2  AXI response, or 2'b10 on timeout.
- rsp_timeout  out  1  response was produced by the watchdog.
- M_AXI_AWADDR, M_AXI_AWVALID (out), M_AXI_AWREADY (in): write address channel.
- M_AXI_AWPROT  out  3  tied to 3'b000.
- M_AXI_WDATA, M_AXI_WVALID (out), M_AXI_WREADY (in): write data channel.
- M_AXI_WSTRB  out  AXI_DW/8  all ones.
- M_AXI_BRESP, M_AXI_BVALID (in), M_AXI_BREADY (out): write response channel.
- M_AXI_ARADDR, M_AXI_ARVALID (out), M_AXI_ARREADY (in): read address channel.
- M_AXI_ARPROT  out  3  tied to 3'b000.
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID (in), M_AXI_RREADY (out): read data channel.

## Operation

- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch addr, wdata and wr.
  - Write: go to WR_AW_W with AWVALID and WVALID set.
  - Read: go to RD_AR with ARVALID set.
- **WR_AW_W**
  - AWVALID clears on the cycle after its AWREADY handshake; WVALID clears independently after its WREADY handshake. AW and W may complete in either order or in the same cycle.
  - Once both handshakes are done, go to WR_B with BREADY = 1.
- **WR_B**
  - On BVALID, capture BRESP and go to RSP.
- **RD_AR**
  - On ARREADY, clear ARVALID and go to RD_R with RREADY = 1.
- **RD_R**
  - On RVALID, capture RDATA and RRESP and go to RSP.
- **RSP**
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - cmd_ready is 0 in every state other than IDLE.
- **Watchdog**
  - The counter clears in IDLE and increments in every other non-RSP state.
  - When the count reaches TIMEOUT_CYC, drop all VALID/READY outputs and go to RSP with rsp_resp = 2'b10 and rsp_timeout = 1.
  - This deliberately violates AXI VALID persistence. It is only for recovery from a hung slave.
- VALID outputs are never raised combinationally from cmd_valid. All AXI outputs are registered.
- Reset mid-transaction: every output returns to its reset value on the next edge, with no response emitted. The slave is expected to be reset from the same domain.

## Timing

- Reset values:
  - cmd_ready = 1.
  - All M_AXI VALID/READY = 0; AWADDR, WDATA, ARADDR = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0.
- Minimum latency with a zero-wait slave (ready/valid already high), cmd accepted at cycle 0:
  - Write: AW/W VALID at cycle 1, BREADY at cycle 2, rsp_valid at cycle 3.
  - Read: ARVALID at cycle 1, RREADY at cycle 2, rsp_valid at cycle 3.
- The next command is accepted at cycle 4 at the earliest.
- rsp_rdata, rsp_resp and rsp_timeout are valid only while rsp_valid = 1, and hold until the next response.

## Structure

- Shared package `lib_axi_pkg`:
  - Response encodings OKAY = 2'b00, SLVERR = 2'b10.
  - FSM state enum.
- Sub-module `lib_watchdog_cnt`: a clearable, enable-gated counter with a terminal-count flag, parameterised by TIMEOUT_CYC.
- Everything else lives in a single module.

## Test plan

- Write 0x004 ← 0xDEADBEEF, zero-wait slave → AW/W VALID at cycle 1, rsp_valid at cycle 3, rsp_resp = 00, rsp_timeout = 0.
- Write with AWREADY delayed 3 cycles and WREADY immediate → WVALID drops after 1 cycle, AWVALID holds 4 cycles, exactly one B handshake, one rsp_valid.
- Read 0x010 with slave RDATA = 0xA5A5_0001, RVALID delayed 5 cycles → rsp_rdata = 0xA5A5_0001 and rsp_valid a single cycle; cmd_ready stays 0 throughout.
- Slave returns BRESP = 2'b10 → rsp_resp = 2'b10, rsp_timeout = 0.
- TIMEOUT_CYC = 16, ARREADY never asserted → ARVALID drops, rsp_valid with rsp_resp = 2'b10 and rsp_timeout = 1 exactly 16 cycles after entering RD_AR; next command accepted.
- M_AXI_ARESET asserted during WR_B → next cycle all VALID/READY = 0, cmd_ready = 1, no rsp_valid.
